mem_port_arbiter: RTL and testbench

Two-requester arbiter for the single-port unified instruction/data memory of the multicycle CPU. Shares the memory between the CPU (fetch and LW/SW traffic) and the program loader/debug port. Each accepted access is latched and driven to the memory for exactly one cycle. For reads, it waits the memory's fixed read latency and returns the data to the owning requester with a one-cycle valid pulse.

---
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the unified memory.
// The arbiter connects through the slave modport; the environment drives master.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt;
  logic              ldr_rvalid;
  logic [DATA_W-1:0] ldr_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output ldr_gnt, ldr_rvalid, ldr_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ldr_gnt, ldr_rvalid, ldr_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the CPU and the loader port: one
// latched access per grant, read data returned after the fixed memory latency.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1,
  parameter bit          RR      = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;
  typedef enum logic {OWN_CPU, OWN_LDR} owner_t;

  state_t            state;
  owner_t            owner;
  owner_t            last;
  logic              lat_we;
  logic [CNT_W-1:0]  cnt;

  logic              pick_ldr_c;
  logic              sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;

  // Loader wins when alone, or on a tie under round-robin when the CPU went last.
  assign pick_ldr_c  = bus.ldr_req && (!bus.cpu_req || (RR && (last == OWN_CPU)));
  assign sel_we_c    = pick_ldr_c ? bus.ldr_we    : bus.cpu_we;
  assign sel_addr_c  = pick_ldr_c ? bus.ldr_addr  : bus.cpu_addr;
  assign sel_wdata_c = pick_ldr_c ? bus.ldr_wdata : bus.cpu_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      owner          <= OWN_CPU;
      last           <= OWN_LDR;
      lat_we         <= 1'b0;
      cnt            <= '0;
      bus.cpu_gnt    <= 1'b0;
      bus.ldr_gnt    <= 1'b0;
      bus.cpu_rvalid <= 1'b0;
      bus.ldr_rvalid <= 1'b0;
      bus.cpu_rdata  <= '0;
      bus.ldr_rdata  <= '0;
      bus.mem_en     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      // Strobes are single-cycle pulses; only the state that owns them re-asserts.
      bus.cpu_gnt    <= 1'b0;
      bus.ldr_gnt    <= 1'b0;
      bus.cpu_rvalid <= 1'b0;
      bus.ldr_rvalid <= 1'b0;
      bus.mem_en     <= 1'b0;
      bus.mem_we     <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.cpu_req || bus.ldr_req) begin
            owner         <= pick_ldr_c ? OWN_LDR : OWN_CPU;
            last          <= pick_ldr_c ? OWN_LDR : OWN_CPU;
            lat_we        <= sel_we_c;
            bus.mem_addr  <= sel_addr_c;
            bus.mem_wdata <= sel_wdata_c;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= sel_we_c;
            bus.cpu_gnt   <= !pick_ldr_c;
            bus.ldr_gnt   <= pick_ldr_c;
            state         <= ACCESS;
          end
        end

        ACCESS: begin
          if (lat_we) begin
            state <= IDLE;
          end else begin
            cnt   <= CNT_W'(MEM_LAT);
            state <= WAIT;
          end
        end

        WAIT: begin
          // Count of 1 marks the cycle in which mem_rdata is valid.
          if (cnt == CNT_W'(1)) begin
            if (owner == OWN_LDR) begin
              bus.ldr_rdata  <= bus.mem_rdata;
              bus.ldr_rvalid <= 1'b1;
            end else begin
              bus.cpu_rdata  <= bus.mem_rdata;
              bus.cpu_rvalid <= 1'b1;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked
// cycle by cycle against a transaction-level schedule of grants and read returns.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LAT_A  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(LAT_A), .RR(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(1), .RR(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  assign bus_b.mem_rdata = '0;

  // Power-up memory contents; addr 5 holds the loader test pattern.
  function automatic logic [31:0] init_word(input logic [7:0] a);
    if (a == 8'h05) return 32'h1234_5678;
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // Synchronous memory for dut_a with LAT_A cycles of read latency.
  logic [31:0] mem   [256];
  bit          mem_v [256];
  logic [31:0] rd_pipe [LAT_A];
  always @(posedge clk) begin
    if (bus_a.mem_en && bus_a.mem_we) begin
      mem[bus_a.mem_addr]   <= bus_a.mem_wdata;
      mem_v[bus_a.mem_addr] <= 1'b1;
    end
    if (bus_a.mem_en && !bus_a.mem_we)
      rd_pipe[0] <= mem_v[bus_a.mem_addr] ? mem[bus_a.mem_addr] : init_word(bus_a.mem_addr);
    for (int i = 1; i < int'(LAT_A); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus_a.mem_rdata = rd_pipe[LAT_A-1];

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference schedule: cycle numbers of the next grant and read return.
  int          k;
  int          next_idle;
  int          gnt_cyc, rv_cyc;
  bit          gnt_ldr, gnt_we, rv_ldr, last_ldr;
  logic [7:0]  acc_addr, exp_maddr;
  logic [31:0] acc_wd, exp_mwd, rv_data, exp_crd, exp_lrd;
  logic [31:0] gold   [256];
  bit          gold_v [256];

  task automatic model_reset();
    gnt_cyc = -1; rv_cyc = -1; next_idle = 0; last_ldr = 1'b1;
    exp_maddr = '0; exp_mwd = '0; exp_crd = '0; exp_lrd = '0;
  endtask

  function automatic logic [5:0] ctrl_a();
    return {bus_a.cpu_gnt, bus_a.ldr_gnt, bus_a.mem_en, bus_a.mem_we,
            bus_a.cpu_rvalid, bus_a.ldr_rvalid};
  endfunction

  // Advance to the next falling edge and compare every dut_a output.
  task automatic tick();
    logic [5:0] e;
    bit g, r;
    @(negedge clk);
    k++;
    g = (k == gnt_cyc);
    r = (k == rv_cyc);
    if (g) begin exp_maddr = acc_addr; exp_mwd = acc_wd; end
    if (r) begin if (rv_ldr) exp_lrd = rv_data; else exp_crd = rv_data; end
    e = {g && !gnt_ldr, g && gnt_ldr, g, g && gnt_we, r && !rv_ldr, r && rv_ldr};
    check_val("ctrl", 64'(ctrl_a()), 64'(e));
    check_val("mem_addr", 64'(bus_a.mem_addr), 64'(exp_maddr));
    check_val("mem_wdata", 64'(bus_a.mem_wdata), 64'(exp_mwd));
    check_val("cpu_rdata", 64'(bus_a.cpu_rdata), 64'(exp_crd));
    check_val("ldr_rdata", 64'(bus_a.ldr_rdata), 64'(exp_lrd));
  endtask

  // Apply the arbitration rules to the requests the DUT samples at the next edge.
  task automatic commit();
    bit take_ldr;
    if (reset && k >= next_idle && (bus_a.cpu_req || bus_a.ldr_req)) begin
      if (bus_a.cpu_req && bus_a.ldr_req) take_ldr = !last_ldr;
      else                                take_ldr = bus_a.ldr_req;
      last_ldr = take_ldr;
      gnt_cyc  = k + 1;
      gnt_ldr  = take_ldr;
      gnt_we   = take_ldr ? bus_a.ldr_we    : bus_a.cpu_we;
      acc_addr = take_ldr ? bus_a.ldr_addr  : bus_a.cpu_addr;
      acc_wd   = take_ldr ? bus_a.ldr_wdata : bus_a.cpu_wdata;
      if (gnt_we) begin
        gold[acc_addr]   = acc_wd;
        gold_v[acc_addr] = 1'b1;
        next_idle = k + 2;
      end else begin
        rv_cyc    = k + 2 + int'(LAT_A);
        rv_ldr    = take_ldr;
        rv_data   = gold_v[acc_addr] ? gold[acc_addr] : init_word(acc_addr);
        next_idle = rv_cyc;
      end
    end
  endtask

  task automatic step();
    tick();
    commit();
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [7:0] a, input logic [31:0] d);
    bus_a.cpu_req = req; bus_a.cpu_we = we; bus_a.cpu_addr = a; bus_a.cpu_wdata = d;
  endtask

  task automatic set_ldr(input bit req, input bit we, input logic [7:0] a, input logic [31:0] d);
    bus_a.ldr_req = req; bus_a.ldr_we = we; bus_a.ldr_addr = a; bus_a.ldr_wdata = d;
  endtask

  int n, rv_k, cg_k, rel, b_cpu, b_ldr;
  bit order[$];
  bit cpu_pend, ldr_pend;
  logic [1:0] eb;

  initial begin
    set_cpu(0, 0, '0, '0);
    set_ldr(0, 0, '0, '0);
    bus_b.cpu_req = 0; bus_b.cpu_we = 1; bus_b.cpu_addr = 8'h01; bus_b.cpu_wdata = 32'h0000_00C1;
    bus_b.ldr_req = 0; bus_b.ldr_we = 1; bus_b.ldr_addr = 8'h02; bus_b.ldr_wdata = 32'h0000_00D2;
    k = 0;
    model_reset();

    // Reset state, then a CPU write to 0x10.
    repeat (3) step();
    reset = 1'b1;
    set_cpu(1, 1, 8'h10, 32'hDEAD_BEEF); commit();
    tick();
    check_val("t1_bus", 64'({bus_a.cpu_gnt, bus_a.mem_en, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata}),
              64'({3'b111, 8'h10, 32'hDEAD_BEEF}));
    set_cpu(0, 0, 8'h10, '0); commit();

    // CPU reads the word back so cpu_rdata is non-zero.
    tick(); set_cpu(1, 0, 8'h10, '0); commit();
    tick(); set_cpu(0, 0, 8'h10, '0); commit();
    step(); step();
    tick();
    check_val("t1_readback", 64'({bus_a.cpu_rvalid, bus_a.cpu_rdata}), 64'({1'b1, 32'hDEAD_BEEF}));

    // Loader read of addr 5 with two-cycle latency.
    n = k;
    set_ldr(1, 0, 8'h05, '0); commit();
    tick();
    check_val("t2_ldr_gnt", 64'({bus_a.ldr_gnt, bus_a.cpu_gnt}), 64'(2'b10));
    set_ldr(0, 0, 8'h05, '0); commit();
    step(); step();
    tick();
    check_val("t2_ldr_rv", 64'({bus_a.ldr_rvalid, bus_a.ldr_rdata}), 64'({1'b1, 32'h1234_5678}));
    check_val("t2_cpu_kept", 64'({bus_a.cpu_rvalid, bus_a.cpu_rdata}), 64'({1'b0, 32'hDEAD_BEEF}));

    // CPU request raised while a loader read is waiting.
    n = k;
    set_ldr(1, 0, 8'h20, '0); commit();
    tick(); set_ldr(0, 0, 8'h20, '0); commit();
    tick(); set_cpu(1, 1, 8'h33, 32'hA5A5_0033); commit();
    rv_k = -1; cg_k = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus_a.ldr_rvalid) rv_k = k;
      if (bus_a.cpu_gnt) begin cg_k = k; set_cpu(0, 0, 8'h33, '0); end
      commit();
    end
    check_val("t3_ldr_rv_cyc", 64'(rv_k - n), 64'd4);
    check_val("t3_cpu_gnt_cyc", 64'(cg_k - n), 64'd5);

    // Reset in the WAIT of a CPU read.
    tick(); set_cpu(1, 0, 8'h10, '0); commit();
    tick(); set_cpu(0, 0, 8'h10, '0); commit();
    tick();
    #2 reset = 1'b0;
    #1;
    check_val("t4_rst_ctrl", 64'({ctrl_a(), bus_a.mem_addr}), '0);
    check_val("t4_rst_rdata", {bus_a.cpu_rdata, bus_a.ldr_rdata}, '0);
    check_val("t4_rst_wdata", 64'(bus_a.mem_wdata), '0);
    model_reset();
    set_cpu(1, 0, 8'h21, '0); commit();
    step(); step();
    reset = 1'b1; commit();
    rel = k; cg_k = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus_a.cpu_gnt && cg_k < 0) begin cg_k = k; set_cpu(0, 0, 8'h21, '0); end
      commit();
    end
    check_val("t4_gnt_after_rel", 64'(cg_k - rel), 64'd1);

    // Both requesters held from reset: RR alternates on dut_a, CPU starves loader on dut_b.
    tick(); reset = 1'b0; model_reset(); commit();
    step();
    set_cpu(1, 1, 8'h40, $urandom);
    set_ldr(1, 1, 8'h41, $urandom);
    bus_b.cpu_req = 1; bus_b.ldr_req = 1;
    reset = 1'b1; commit();
    b_cpu = 0; b_ldr = 0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (bus_a.cpu_gnt) begin order.push_back(1'b0); set_cpu(1, 1, 8'h40, $urandom); end
      if (bus_a.ldr_gnt) begin order.push_back(1'b1); set_ldr(1, 1, 8'h41, $urandom); end
      eb = {1'(i % 2), 1'b0};
      check_val("t6_b_gnt", 64'({bus_b.cpu_gnt, bus_b.ldr_gnt}), 64'(eb));
      b_cpu += int'(bus_b.cpu_gnt);
      b_ldr += int'(bus_b.ldr_gnt);
      if (i == 11) begin
        set_cpu(0, 0, '0, '0); set_ldr(0, 0, '0, '0);
        bus_b.cpu_req = 0; bus_b.ldr_req = 0;
      end
      commit();
    end
    check_val("t5_grants", 64'(order.size()), 64'd6);
    for (int i = 0; i < 6 && i < order.size(); i++)
      check_val($sformatf("t5_order%0d", i), 64'(order[i]), 64'(i % 2));
    check_val("t6_b_cpu_cnt", 64'(b_cpu), 64'd6);
    check_val("t6_b_ldr_cnt", 64'(b_ldr), 64'd0);

    // Random traffic on both requesters.
    cpu_pend = 0; ldr_pend = 0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      if (cpu_pend && bus_a.cpu_gnt) begin cpu_pend = 0; set_cpu(0, 0, '0, '0); end
      if (ldr_pend && bus_a.ldr_gnt) begin ldr_pend = 0; set_ldr(0, 0, '0, '0); end
      if (!cpu_pend && $urandom_range(0, 2) == 0) begin
        cpu_pend = 1;
        set_cpu(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), $urandom);
      end
      if (!ldr_pend && $urandom_range(0, 2) == 0) begin
        ldr_pend = 1;
        set_ldr(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), $urandom);
      end
      commit();
    end
    tick();
    set_cpu(0, 0, '0, '0); set_ldr(0, 0, '0, '0);
    commit();
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
